patch_controller: RTL and testbench

PATCH_CONTROLLER -- requirements
Module: patch_controller

---
 rtl/patch_controller.sv | 155 +++++++++++++++
 tb/tb_patch_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/patch_controller.sv
// Patch controller: watches a masked trigger pattern on an observe bus and overrides
// selected control bits for a programmed hold time. Optional feature macro: PATCH_EVENT_CNT_EN.
module patch_controller #(
  parameter int OBS_W  = 10,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 8,
  parameter int CFG_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OBS_W-1:0]  observe_port,
  input  logic [CTRL_W-1:0] control_port_in,
  output logic [CTRL_W-1:0] control_port_out,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              patch_active,
  output logic              armed
`ifdef PATCH_EVENT_CNT_EN
  ,
  output logic [15:0]       patch_events
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_PATCH = 2'd2;

  localparam logic [CNT_W-1:0] ONE   = 1;
  localparam logic [CNT_W:0]   ONE_W = 1;

  logic [1:0]        state;
  logic [OBS_W-1:0]  trig_mask;
  logic [OBS_W-1:0]  trig_value;
  logic [CTRL_W-1:0] ctrl_mask;
  logic [CTRL_W-1:0] ctrl_value;
  logic [CTRL_W-1:0] act_mask;
  logic [CTRL_W-1:0] act_value;
  logic [CNT_W-1:0]  match_target;
  logic [CNT_W-1:0]  hold_cycles;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  hold_cnt;

  logic             wr_en;
  logic             arm_cmd;
  logic             disarm_cmd;
  logic             match;
  logic [CNT_W:0]   cnt_plus;
  logic [CNT_W:0]   eff_target;
  logic             target_hit;
  logic             enter_patch;
  logic             cfg_unused;

  assign cfg_ready  = ~rst;
  assign wr_en      = cfg_valid & cfg_ready;
  assign arm_cmd    = wr_en && (cfg_addr == 3'd6) && cfg_data[0];
  assign disarm_cmd = wr_en && (cfg_addr == 3'd6) && cfg_data[1];
  assign cfg_unused = ^cfg_data;

  assign match = (((observe_port ^ trig_value) & trig_mask) == '0);

  // A target of zero is treated as one so a single match always suffices.
  assign cnt_plus    = {1'b0, match_cnt} + ONE_W;
  assign eff_target  = (match_target == '0) ? ONE_W : {1'b0, match_target};
  assign target_hit  = (cnt_plus >= eff_target);
  assign enter_patch = (state == S_ARMED) && match && target_hit && !disarm_cmd;

  assign patch_active = (state == S_PATCH);
  assign armed        = (state == S_ARMED);

  assign control_port_out = (state == S_PATCH)
                          ? ((control_port_in & ~act_mask) | (act_value & act_mask))
                          : control_port_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_mask    <= '0;
      trig_value   <= '0;
      ctrl_mask    <= '0;
      ctrl_value   <= '0;
      match_target <= '0;
      hold_cycles  <= '0;
      act_mask     <= '0;
      act_value    <= '0;
    end else begin
      if (wr_en) begin
        case (cfg_addr)
          3'd0:    trig_mask    <= cfg_data[OBS_W-1:0];
          3'd1:    trig_value   <= cfg_data[OBS_W-1:0];
          3'd2:    ctrl_mask    <= cfg_data[CTRL_W-1:0];
          3'd3:    ctrl_value   <= cfg_data[CTRL_W-1:0];
          3'd4:    match_target <= cfg_data[CNT_W-1:0];
          3'd5:    hold_cycles  <= cfg_data[CNT_W-1:0];
          default: ;
        endcase
      end
      // Active override set is frozen while patching so mid-patch writes wait for exit.
      if (state != S_PATCH) begin
        act_mask  <= ctrl_mask;
        act_value <= ctrl_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      match_cnt <= '0;
      hold_cnt  <= '0;
    end else if (disarm_cmd) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_cmd) begin
            state     <= S_ARMED;
            match_cnt <= '0;
          end
        end
        S_ARMED: begin
          if (match) begin
            match_cnt <= (&match_cnt) ? match_cnt : cnt_plus[CNT_W-1:0];
            if (target_hit) begin
              state    <= S_PATCH;
              hold_cnt <= hold_cycles;
            end
          end
        end
        S_PATCH: begin
          // A zero hold count keeps the patch applied until disarmed.
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - ONE;
            if (hold_cnt == ONE) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PATCH_EVENT_CNT_EN
  logic [15:0] event_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      event_cnt <= '0;
    else if (enter_patch && (event_cnt != 16'hFFFF))
      event_cnt <= event_cnt + 16'd1;
  end

  assign patch_events = event_cnt;
`endif

endmodule

// File: tb/tb_patch_controller.sv
// Scoreboard bench for patch_controller: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_patch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  observe_port;
  logic [10:0] control_port_in;
  logic [10:0] control_port_out;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        patch_active;
  logic        armed;
`ifdef PATCH_EVENT_CNT_EN
  logic [15:0] patch_events;
`endif

  always #5 clk = ~clk;

  patch_controller dut (
    .clk              (clk),
    .rst              (rst),
    .observe_port     (observe_port),
    .control_port_in  (control_port_in),
    .control_port_out (control_port_out),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .patch_active     (patch_active),
    .armed            (armed)
`ifdef PATCH_EVENT_CNT_EN
    ,
    .patch_events     (patch_events)
`endif
  );

  // Passthrough value, override with value 0x008 and with value 0x7FF under mask 0x00C.
  localparam logic [10:0] PASS    = 11'h555;
  localparam logic [10:0] OVR     = 11'h559;
  localparam logic [10:0] OVR_NEW = 11'h55D;

  typedef struct {
    string       nm;
    logic [10:0] out;
    logic        pa;
    logic        arm;
    logic        rdy;
    logic [15:0] ev;
    bit          ev_chk;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] ev_exp = 16'h0;
  bit          ev_chk = 1'b0;

  task automatic cmpField(input string nm, input string fld, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%h exp=%h", nm, fld, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField(e.nm, "out",   {5'b0, control_port_out}, {5'b0, e.out});
    cmpField(e.nm, "patch", {15'b0, patch_active},    {15'b0, e.pa});
    cmpField(e.nm, "armed", {15'b0, armed},           {15'b0, e.arm});
    cmpField(e.nm, "ready", {15'b0, cfg_ready},       {15'b0, e.rdy});
`ifdef PATCH_EVENT_CNT_EN
    if (e.ev_chk) cmpField(e.nm, "events", patch_events, e.ev);
`endif
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) checkOutput(sb.pop_front());
  end

  // Drives one cycle of inputs just after the edge; expectations describe this same cycle.
  task automatic applyStimulus(input string nm, input logic [9:0] o, input logic [10:0] ci,
                               input logic v, input logic [2:0] a, input logic [15:0] d,
                               input logic r, input logic [10:0] eo, input logic epa,
                               input logic earm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; observe_port = o; control_port_in = ci;
    cfg_valid = v; cfg_addr = a; cfg_data = d;
    e.nm = nm; e.out = eo; e.pa = epa; e.arm = earm; e.rdy = ~r;
    e.ev = ev_exp; e.ev_chk = ev_chk;
    sb.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [9:0] o, input logic [10:0] eo,
                     input logic epa, input logic earm);
    applyStimulus(nm, o, PASS, 1'b0, 3'd0, 16'h0, 1'b0, eo, epa, earm);
  endtask

  task automatic wr(input string nm, input logic [2:0] a, input logic [15:0] d,
                    input logic [10:0] eo, input logic epa, input logic earm);
    applyStimulus(nm, 10'h0, PASS, 1'b1, a, d, 1'b0, eo, epa, earm);
  endtask

`ifdef PATCH_EVENT_CNT_EN
  task automatic trigSeq(input logic [15:0] before, input logic [15:0] after);
    ev_exp = before;
    wr("t6_arm", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t6_armed", 10'h2AA, PASS, 1'b0, 1'b1);
    ev_exp = after;
    cyc("t6_patch", 10'h0, PASS, 1'b1, 1'b0);
    wr("t6_disarm", 3'd6, 16'h2, PASS, 1'b1, 1'b0);
    cyc("t6_idle", 10'h0, PASS, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; observe_port = '0; control_port_in = PASS;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;

    applyStimulus("rst0", 10'h0, PASS, 1'b0, 3'd0, 16'h0, 1'b1, PASS, 1'b0, 1'b0);
    applyStimulus("rst1", 10'h0, PASS, 1'b0, 3'd0, 16'h0, 1'b1, PASS, 1'b0, 1'b0);

    // Basic trigger: two matches, hold 3, bits[3:2] forced to 2'b10.
    wr("t1_tmask", 3'd0, 16'h03FF, PASS, 1'b0, 1'b0);
    wr("t1_tval",  3'd1, 16'h0015, PASS, 1'b0, 1'b0);
    wr("t1_cmask", 3'd2, 16'h000C, PASS, 1'b0, 1'b0);
    wr("t1_cval",  3'd3, 16'h0008, PASS, 1'b0, 1'b0);
    wr("t1_tgt",   3'd4, 16'h0002, PASS, 1'b0, 1'b0);
    wr("t1_hold",  3'd5, 16'h0003, PASS, 1'b0, 1'b0);
    wr("t1_arm",   3'd6, 16'h0001, PASS, 1'b0, 1'b0);
    cyc("t1_m1", 10'h015, PASS, 1'b0, 1'b1);
    cyc("t1_nm", 10'h014, PASS, 1'b0, 1'b1);
    cyc("t1_m2", 10'h015, PASS, 1'b0, 1'b1);
    cyc("t1_p1", 10'h000, OVR, 1'b1, 1'b0);
    applyStimulus("t1_p2", 10'h0, 11'h0F3, 1'b0, 3'd0, 16'h0, 1'b0, 11'h0FB, 1'b1, 1'b0);
    cyc("t1_p3", 10'h000, OVR, 1'b1, 1'b0);
    cyc("t1_exit", 10'h000, PASS, 1'b0, 1'b0);
    cyc("t1_idle", 10'h015, PASS, 1'b0, 1'b0);

    // Sticky patch with hold 0, released by disarm.
    wr("t2_hold", 3'd5, 16'h0, PASS, 1'b0, 1'b0);
    wr("t2_tgt",  3'd4, 16'h0, PASS, 1'b0, 1'b0);
    wr("t2_arm",  3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t2_armed", 10'h015, PASS, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cyc("t2_sticky", 10'h0, OVR, 1'b1, 1'b0);
    wr("t2_disarm", 3'd6, 16'h2, OVR, 1'b1, 1'b0);
    cyc("t2_pass", 10'h0, PASS, 1'b0, 1'b0);

    // Shadow write during patch only applies to the next trigger.
    wr("t3_arm", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t3_armed", 10'h015, PASS, 1'b0, 1'b1);
    cyc("t3_p", 10'h0, OVR, 1'b1, 1'b0);
    wr("t3_wval", 3'd3, 16'h07FF, OVR, 1'b1, 1'b0);
    cyc("t3_keep1", 10'h0, OVR, 1'b1, 1'b0);
    cyc("t3_keep2", 10'h0, OVR, 1'b1, 1'b0);
    wr("t3_disarm", 3'd6, 16'h2, OVR, 1'b1, 1'b0);
    cyc("t3_idle", 10'h0, PASS, 1'b0, 1'b0);
    wr("t3_rearm", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t3_armed2", 10'h015, PASS, 1'b0, 1'b1);
    cyc("t3_new", 10'h0, OVR_NEW, 1'b1, 1'b0);
    wr("t3_disarm2", 3'd6, 16'h2, OVR_NEW, 1'b1, 1'b0);
    cyc("t3_idle2", 10'h0, PASS, 1'b0, 1'b0);

    // Arm while armed is ignored; disarm from ARMED; arm+disarm together.
    wr("t4_tgt", 3'd4, 16'h3, PASS, 1'b0, 1'b0);
    wr("t4_arm", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t4_m1", 10'h015, PASS, 1'b0, 1'b1);
    applyStimulus("t4_rearm", 10'h015, PASS, 1'b1, 3'd6, 16'h1, 1'b0, PASS, 1'b0, 1'b1);
    cyc("t4_m3", 10'h015, PASS, 1'b0, 1'b1);
    cyc("t4_p", 10'h0, OVR_NEW, 1'b1, 1'b0);
    wr("t4_disarm", 3'd6, 16'h2, OVR_NEW, 1'b1, 1'b0);
    cyc("t4_idle", 10'h0, PASS, 1'b0, 1'b0);
    wr("t4_arm2", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t4_ar", 10'h0, PASS, 1'b0, 1'b1);
    wr("t4_dis_armed", 3'd6, 16'h2, PASS, 1'b0, 1'b1);
    cyc("t4_idle2", 10'h015, PASS, 1'b0, 1'b0);
    wr("t4_both", 3'd6, 16'h3, PASS, 1'b0, 1'b0);
    cyc("t4_both_a", 10'h015, PASS, 1'b0, 1'b0);
    cyc("t4_both_b", 10'h015, PASS, 1'b0, 1'b0);

    // Reset during patch: passthrough next cycle, rejected write, cleared registers.
    wr("t5_tgt", 3'd4, 16'h0, PASS, 1'b0, 1'b0);
    wr("t5_arm", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t5_armed", 10'h015, PASS, 1'b0, 1'b1);
    cyc("t5_p", 10'h0, OVR_NEW, 1'b1, 1'b0);
    applyStimulus("t5_rst", 10'h0, PASS, 1'b1, 3'd0, 16'h03FF, 1'b1, OVR_NEW, 1'b1, 1'b0);
    applyStimulus("t5_rst2", 10'h2AA, PASS, 1'b1, 3'd0, 16'h03FF, 1'b1, PASS, 1'b0, 1'b0);
    cyc("t5_post", 10'h2AA, PASS, 1'b0, 1'b0);
    wr("t5_arm2", 3'd6, 16'h1, PASS, 1'b0, 1'b0);
    cyc("t5_armed2", 10'h2AA, PASS, 1'b0, 1'b1);
    cyc("t5_zero1", 10'h2AA, PASS, 1'b1, 1'b0);
    applyStimulus("t5_zero2", 10'h2AA, 11'h0F3, 1'b0, 3'd0, 16'h0, 1'b0, 11'h0F3, 1'b1, 1'b0);
    cyc("t5_zero3", 10'h2AA, PASS, 1'b1, 1'b0);
    wr("t5_disarm", 3'd6, 16'h2, PASS, 1'b1, 1'b0);
    cyc("t5_idle", 10'h0, PASS, 1'b0, 1'b0);

`ifdef PATCH_EVENT_CNT_EN
    applyStimulus("t6_rst", 10'h0, PASS, 1'b0, 3'd0, 16'h0, 1'b1, PASS, 1'b0, 1'b0);
    ev_chk = 1'b1;
    trigSeq(16'd0, 16'd1);
    trigSeq(16'd1, 16'd2);
    trigSeq(16'd2, 16'd3);
    @(negedge clk);
    #1;
    force dut.event_cnt = 16'hFFFF;
    #1;
    release dut.event_cnt;
    trigSeq(16'hFFFF, 16'hFFFF);
    ev_chk = 1'b0;
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
